// File: rtl/aes_pkg.sv
// ============================================================================
// Module      : aes_pkg
// Description : Shared widths, mode encodings and FSM state type for the
//               AES request arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

    localparam int AES_KEY_W = 256;
    localparam int AES_BLK_W = 128;

    localparam logic [1:0] MODE_AES128  = 2'b00;
    localparam logic [1:0] MODE_AES192  = 2'b01;
    localparam logic [1:0] MODE_AES256  = 2'b10;
    localparam logic [1:0] MODE_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/aes_req_arbiter_if.sv
// ============================================================================
// Module      : aes_req_arbiter_if
// Description : Requester, response and core-side bundle of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface aes_req_arbiter_if #(
    parameter int NUM_REQ = 2
);
    import aes_pkg::*;

    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ-1:0]                req_ready;
    logic [NUM_REQ-1:0]                req_enc_dec;
    logic [NUM_REQ-1:0][1:0]           req_mode;
    logic [NUM_REQ-1:0][AES_KEY_W-1:0] req_key;
    logic [NUM_REQ-1:0][AES_BLK_W-1:0] req_data;

    logic                              rsp_valid;
    logic                              rsp_ready;
    logic [IDW-1:0]                    rsp_id;
    logic [AES_BLK_W-1:0]              rsp_data;
    logic                              rsp_err;

    logic                              core_start;
    logic                              core_enc_dec;
    logic [1:0]                        core_mode;
    logic [AES_KEY_W-1:0]              core_key;
    logic [AES_BLK_W-1:0]              core_data_in;
    logic                              core_done;
    logic [AES_BLK_W-1:0]              core_data_out;

    // Arbiter side
    modport slave (
        input  req_valid, req_enc_dec, req_mode, req_key, req_data,
        input  rsp_ready, core_done, core_data_out,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
        output core_start, core_enc_dec, core_mode, core_key, core_data_in
    );

    // Requesters, response consumer and core side
    modport master (
        output req_valid, req_enc_dec, req_mode, req_key, req_data,
        output rsp_ready, core_done, core_data_out,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
        input  core_start, core_enc_dec, core_mode, core_key, core_data_in
    );

endinterface

`default_nettype wire

// File: rtl/aes_req_arbiter_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker; search starts at i_ptr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  wire logic [NUM_REQ-1:0] i_req,
    input  wire logic [IDW-1:0]     i_ptr,
    output logic      [NUM_REQ-1:0] o_gnt,
    output logic      [IDW-1:0]     o_idx,
    output logic                    o_any
);

    int             w_pos;
    logic [IDW-1:0] w_sel;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_pos = 0;
        w_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_pos = int'(i_ptr) + i;
            if (w_pos >= NUM_REQ) begin
                w_pos = w_pos - NUM_REQ;
            end
            w_sel = IDW'(w_pos);
            if (!o_any && i_req[w_sel]) begin
                o_any        = 1'b1;
                o_gnt[w_sel] = 1'b1;
                o_idx        = w_sel;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/aes_req_arbiter.sv
// ============================================================================
// Module      : aes_req_arbiter
// Description : Shares one AES core among NUM_REQ requesters, one job at a
//               time, with illegal-mode rejection and a completion watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_req_arbiter
    import aes_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 64
) (
    input  wire logic      clk,
    input  wire logic      reset,
    aes_req_arbiter_if.slave bus
);

    localparam int             IDW       = $clog2(NUM_REQ);
    localparam int             WDW       = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] C_TIMEOUT = WDW'(TIMEOUT);
    localparam logic [IDW-1:0] C_LAST_ID = IDW'(NUM_REQ - 1);

    state_t               r_state;
    logic [IDW-1:0]       r_rr_ptr;
    logic [IDW-1:0]       r_id;
    logic                 r_enc_dec;
    logic [1:0]           r_mode;
    logic [AES_KEY_W-1:0] r_key;
    logic [AES_BLK_W-1:0] r_data;
    logic                 r_core_start;
    logic [WDW-1:0]       r_wd;
    logic                 r_rsp_valid;
    logic                 r_rsp_err;
    logic [AES_BLK_W-1:0] r_rsp_data;

    logic [NUM_REQ-1:0]   w_gnt;
    logic [IDW-1:0]       w_gnt_idx;
    logic                 w_gnt_any;
    logic                 w_idle_open;
    logic                 w_hs;
    logic [WDW-1:0]       w_wd_next;
    logic [IDW-1:0]       w_ptr_next;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .i_req   (bus.req_valid),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_gnt),
        .o_idx   (w_gnt_idx),
        .o_any   (w_gnt_any)
    );

    // Grants are only offered while idle and out of reset; the handshake
    // completes in the same cycle the grant is shown.
    assign w_idle_open   = (r_state == ST_IDLE) && !reset;
    assign bus.req_ready = w_idle_open ? w_gnt : '0;
    assign w_hs          = w_idle_open && w_gnt_any;
    assign w_wd_next     = r_wd + 1'b1;
    assign w_ptr_next    = (r_id == C_LAST_ID) ? '0 : r_id + 1'b1;

    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_id       = r_id;
    assign bus.rsp_data     = r_rsp_data;
    assign bus.rsp_err      = r_rsp_err;
    assign bus.core_start   = r_core_start;
    assign bus.core_enc_dec = r_enc_dec;
    assign bus.core_mode    = r_mode;
    assign bus.core_key     = r_key;
    assign bus.core_data_in = r_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_rr_ptr     <= '0;
            r_id         <= '0;
            r_enc_dec    <= 1'b0;
            r_mode       <= '0;
            r_key        <= '0;
            r_data       <= '0;
            r_core_start <= 1'b0;
            r_wd         <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_data   <= '0;
        end else begin
            r_core_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_hs) begin
                        r_id      <= w_gnt_idx;
                        r_enc_dec <= bus.req_enc_dec[w_gnt_idx];
                        r_mode    <= bus.req_mode[w_gnt_idx];
                        r_key     <= bus.req_key[w_gnt_idx];
                        r_data    <= bus.req_data[w_gnt_idx];
                        r_wd      <= '0;
                        if (bus.req_mode[w_gnt_idx] == MODE_ILLEGAL) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_data  <= '0;
                        end else begin
                            r_state      <= ST_START;
                            r_core_start <= 1'b1;
                        end
                    end
                end
                ST_START: begin
                    // Watchdog counts the start cycle as cycle 1.
                    r_state <= ST_BUSY;
                    r_wd    <= w_wd_next;
                end
                ST_BUSY: begin
                    r_wd <= w_wd_next;
                    if (bus.core_done) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_data  <= bus.core_data_out;
                    end else if (w_wd_next == C_TIMEOUT) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_data  <= '0;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rr_ptr    <= w_ptr_next;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aes_req_arbiter.sv
// ============================================================================
// Module      : tb_aes_req_arbiter
// Description : Directed self-checking bench with an XOR core stub.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_req_arbiter;

    localparam logic [127:0] C_DATA0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_KEY0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_RES0  = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] C_DATA1 = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] C_KEY1  = 128'h11111111111111111111111111111111;
    localparam logic [127:0] C_RES1  = 128'h1e1f1c1d1a1b18191617141512131011;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;
    int   r_stub_cnt = 0;
    int   stub_delay = 0;
    int   r_n_start  = 0;

    aes_req_arbiter_if #(.NUM_REQ(2)) bus ();

    aes_req_arbiter #(
        .NUM_REQ (2),
        .TIMEOUT (64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Core stub: done pulses stub_delay cycles after core_start (0 = never).
    always @(posedge clk) begin
        if (bus.core_start) begin
            r_stub_cnt <= 1;
        end else if (r_stub_cnt != 0) begin
            r_stub_cnt <= (r_stub_cnt == stub_delay) ? 0 : r_stub_cnt + 1;
        end
        if (bus.core_start) begin
            r_n_start <= r_n_start + 1;
        end
    end

    assign bus.core_done     = (stub_delay != 0) && (r_stub_cnt == stub_delay);
    assign bus.core_data_out = bus.core_data_in ^ bus.core_key[127:0];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic run_job(input int delay, input int hold, input int exp_gid,
                           input int exp_lat, input int exp_starts,
                           input logic [127:0] exp_data, input logic exp_err);
        int   n;
        int   lat;
        int   starts0;
        logic cs;
        stub_delay = delay;
        n = 0;
        while (bus.req_ready == 2'b00 && n < 20) begin
            step();
            n++;
        end
        check("grant_seen", {31'd0, bus.req_ready != 2'b00}, 1);
        check("grant_id", bus.req_ready, (exp_gid == 1) ? 2'b10 : 2'b01);
        starts0 = r_n_start;
        step();
        cs  = bus.core_start;
        lat = 0;
        while (!bus.rsp_valid && lat < 200) begin
            check("no_regrant", bus.req_ready, 0);
            step();
            lat++;
        end
        check("rsp_latency", lat, exp_lat);
        check("start_pulse", cs, (exp_starts != 0));
        check("start_count", r_n_start - starts0, exp_starts);
        check("rsp_id", bus.rsp_id, exp_gid);
        check("rsp_data", bus.rsp_data, exp_data);
        check("rsp_err", bus.rsp_err, exp_err);
        for (int i = 0; i < hold; i++) begin
            step();
            check("hold_valid", bus.rsp_valid, 1);
            check("hold_id", bus.rsp_id, exp_gid);
            check("hold_data", bus.rsp_data, exp_data);
            check("hold_err", bus.rsp_err, exp_err);
            check("hold_noready", bus.req_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check("rsp_drop", bus.rsp_valid, 0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        bus.req_valid   = 2'b11;
        bus.req_enc_dec = 2'b01;
        bus.req_mode    = '0;
        bus.req_key[0]  = {128'd0, C_KEY0};
        bus.req_key[1]  = {128'd0, C_KEY1};
        bus.req_data[0] = C_DATA0;
        bus.req_data[1] = C_DATA1;
        bus.rsp_ready   = 1'b0;

        // Reset state, with requests pending during reset
        step();
        step();
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_core_start", bus.core_start, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_rsp_id", bus.rsp_id, 0);
        check("rst_core_key", bus.core_key, 0);
        check("rst_core_data", bus.core_data_in, 0);
        bus.req_valid = 2'b00;
        reset = 1'b0;
        step();

        // Single job from requester 0, done 11 cycles after start
        bus.req_valid = 2'b01;
        #1;
        run_job(11, 0, 0, 12, 1, C_RES0, 1'b0);
        bus.req_valid = 2'b00;
        check("core_key", bus.core_key, {128'd0, C_KEY0});
        check("core_data_in", bus.core_data_in, C_DATA0);
        check("core_mode", bus.core_mode, 2'b00);
        check("core_enc_dec", bus.core_enc_dec, 1'b1);

        // Both requesting: order 0,1,0; last response held 10 cycles
        pulse_reset();
        bus.req_valid = 2'b11;
        #1;
        run_job(5, 0, 0, 6, 1, C_RES0, 1'b0);
        run_job(5, 0, 1, 6, 1, C_RES1, 1'b0);
        run_job(5, 10, 0, 6, 1, C_RES0, 1'b0);
        bus.req_valid = 2'b00;

        // Illegal mode on requester 1
        bus.req_mode[1] = 2'b11;
        bus.req_valid   = 2'b10;
        #1;
        run_job(0, 0, 1, 0, 0, 128'd0, 1'b1);
        bus.req_valid   = 2'b00;
        bus.req_mode[1] = 2'b00;

        // Watchdog expiry, then done on the last possible cycle
        bus.req_valid = 2'b01;
        #1;
        run_job(0, 0, 0, 64, 1, 128'd0, 1'b1);
        bus.req_valid = 2'b00;
        step();
        bus.req_valid = 2'b01;
        #1;
        run_job(63, 0, 0, 64, 1, C_RES0, 1'b0);
        bus.req_valid = 2'b00;
        step();

        // Reset while busy; the late done must be ignored
        stub_delay    = 8;
        bus.req_valid = 2'b01;
        #1;
        check("mid_grant", bus.req_ready, 2'b01);
        step();
        bus.req_valid = 2'b00;
        check("mid_start", bus.core_start, 1);
        for (int i = 0; i < 5; i++) step();
        reset = 1'b1;
        step();
        check("mid_start_low", bus.core_start, 0);
        check("mid_rsp_low", bus.rsp_valid, 0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("mid_no_rsp", bus.rsp_valid, 0);
            check("mid_no_start", bus.core_start, 0);
        end
        bus.req_valid = 2'b11;
        #1;
        check("mid_idle_grant", bus.req_ready, 2'b01);
        run_job(5, 0, 0, 6, 1, C_RES0, 1'b0);
        bus.req_valid = 2'b00;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=stuck exp=finish");
        $fatal(1, "bench time limit");
    end

endmodule

`default_nettype wire
